sprite_dma: RTL
===============

# sprite_dma

Bus-mastering block copy engine on the CPU's external bus. A CPU write to a trigger address latches a source page. The block then pulls the CPU's ready input low and takes the address/data bus. It copies 256 bytes from `{page,8'h00}..{page,8'hFF}` to one fixed destination register, then hands the bus back. It sits between the CPU's bus pins (`o_ab`/`o_rw`/`io_db`/`i_rdy`) and the system bus mux.

## Interface
Parameters:
- `TRIGGER_ADDR`, default 16'h4014: address whose CPU write starts a transfer.
- `DEST_ADDR`, default 16'h2004: fixed write target for every copied byte.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_x` in 1: reset, asynchronous, active-low.
- `cpu_ab` in 16: CPU address bus.
- `cpu_rw` in 1: CPU R/W; 1 = read, 0 = write.
- `cpu_db` in 8: data driven by the CPU during write cycles.
- `bus_db` in 8: read data returned by the memory system.
- `o_rdy` out 1: drives CPU `i_rdy`; 0 = halt CPU.
- `dma_active` out 1: 1 = bus mux selects DMA address/rw/data instead of CPU.
- `dma_ab` out 16: DMA address.
- `dma_rw` out 1: DMA R/W.
- `dma_db` out 8: DMA write data.
- `o_done` out 1: one-cycle pulse when a transfer completes.

## Operation
- Registers:
  - `state` ∈ {IDLE, HALT, ALIGN, READ, WRITE}.
  - `page[7:0]` and `idx[7:0]`.
  - `buf[7:0]` holds the byte being copied.
  - `parity` is a free-running 1-bit toggle that flips every cycle.
  - `o_done` is registered.
- All other outputs are decoded from registered state (Moore); none depend combinationally on inputs.
- IDLE:
  - Trigger condition: `cpu_ab==TRIGGER_ADDR && cpu_rw==0`.
  - On trigger: `page<=cpu_db`, `idx<=0`, go to HALT.
  - Triggers are sampled only in IDLE. Writes seen in any other state are ignored, including the DMA's own writes.
- HALT:
  - The CPU may still be completing write cycles, which a halted 6502 does not freeze on.
  - Stay in HALT while `cpu_rw==0`.
  - When `cpu_rw==1`: go to ALIGN if `parity==1` in that cycle, else go to READ.
- ALIGN: one dummy cycle, then READ.
- READ:
  - Drive `dma_ab={page,idx}` with `dma_rw=1`.
  - Capture `buf<=bus_db` at the end of the cycle.
  - Go to WRITE.
- WRITE:
  - Drive `dma_ab=DEST_ADDR`, `dma_rw=0`, `dma_db=buf`.
  - `idx<=idx+1`, 8-bit, wrapping to 0.
  - If `idx==8'hFF`: go to IDLE and set `o_done<=1`. Otherwise go to READ.
- Output decode:
  - `o_rdy` = 1 only in IDLE.
  - `dma_active` = 1 only in READ and WRITE.
  - Outside READ/WRITE: `dma_ab=16'h0000`, `dma_rw=1`, `dma_db=8'h00`.
- Page `8'hFF` reads FF00..FFFF. There is no carry into the page; the address never leaves the page.

## Timing
- Reset values:
  - state IDLE, `o_rdy=1`, `dma_active=0`, `dma_ab=0`, `dma_rw=1`, `dma_db=0`, `o_done=0`.
  - `page=0`, `idx=0`, `buf=0`, `parity=0`.
- Transfer sequence, with the trigger write in cycle N:
  - Cycle N+1: HALT, `o_rdy=0`.
  - Stall cycles: H ≥ 1 HALT cycles, plus A ∈ {0,1} ALIGN cycles, plus 512 READ/WRITE cycles.
  - First IDLE cycle after the last WRITE: `o_rdy=1` and `o_done=1`, for that cycle only.
  - Total `o_rdy=0` cycles = H + A + 512. Common case is 513 (even) or 514 (odd).
- READ and WRITE strictly alternate. `idx` increments once per WRITE. Exactly 256 writes per transfer.
- `bus_db` must be valid by the end of the READ cycle (zero-wait memory).
- Reset during any state: immediately return to the reset values. A partial transfer is abandoned and is not resumed. The next trigger restarts at `idx=0`.
- A trigger and reset deasserting in the same cycle: no trigger is taken in the first cycle after reset.

## Test plan
- Reset: hold `rst_x=0` mid-clock → all outputs at reset values asynchronously. Release → IDLE, `o_rdy=1`.
- Even-parity copy:
  - Stimulus: memory[0x0200+i]=i^8'h5A; CPU writes 8'h02 to 16'h4014 with `parity=0` at HALT exit; `cpu_rw=1` in HALT.
  - Required: 256 reads at 0200..02FF, each followed by a write to 2004 of i^5A; `o_rdy=0` for exactly 513 cycles; single `o_done` pulse.
- Odd parity: same stimulus with `parity=1` at HALT exit → one ALIGN cycle, `dma_active=0` in it; `o_rdy=0` for 514 cycles.
- Write backlog: hold `cpu_rw=0` for 3 cycles after the trigger → HALT lasts 3 cycles; first READ delayed by 2 cycles versus the baseline; data unchanged.
- Page wrap and non-triggers:
  - Writing 8'hFF to 4014 → reads FF00..FFFF only, with no access at 0000.
  - A CPU read of 4014, or a write to 4015 → no transfer; `o_rdy` stays 1.
- Reset mid-transfer: assert `rst_x` after 100 writes → `dma_active=0` and `o_rdy=1` at once; `o_done` stays 0. A new trigger with page 8'h03 → first read at 0300.

Source files
------------

// File: rtl/sprite_dma.sv
// sprite_dma: bus-mastering 256-byte block copy engine.
// A CPU write to TRIGGER_ADDR latches a source page. The engine halts the CPU,
// then copies {page,00}..{page,FF} byte by byte into DEST_ADDR with strictly
// alternating READ/WRITE cycles, then returns the bus and pulses o_done.
// Bus outputs are decoded from the registered state only (Moore).
// o_state exposes the FSM encoding for debug and checker binding.
module sprite_dma #(
    parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
    parameter logic [15:0] DEST_ADDR    = 16'h2004
) (
    input  logic        clk,
    input  logic        rst_x,
    input  logic [15:0] cpu_ab,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_db,
    input  logic [7:0]  bus_db,
    output logic        o_rdy,
    output logic        dma_active,
    output logic [15:0] dma_ab,
    output logic        dma_rw,
    output logic [7:0]  dma_db,
    output logic        o_done,
    output logic [2:0]  o_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t     r_state;
    logic [7:0] r_page;
    logic [7:0] r_idx;
    logic [7:0] r_buf;
    logic       r_parity;
    logic       r_done;
    // Low for the first clock after reset so a trigger overlapping reset
    // release is not taken.
    logic       r_armed;
    logic       w_trigger;

    assign w_trigger = r_armed && (cpu_ab == TRIGGER_ADDR) && !cpu_rw;

    // Transfer FSM, page/index/data registers, parity toggle and done pulse.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            r_state  <= IDLE;
            r_page   <= 8'h00;
            r_idx    <= 8'h00;
            r_buf    <= 8'h00;
            r_parity <= 1'b0;
            r_done   <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_parity <= ~r_parity;
            r_armed  <= 1'b1;
            r_done   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_trigger) begin
                        r_page  <= cpu_db;
                        r_idx   <= 8'h00;
                        r_state <= HALT;
                    end
                end
                HALT: begin
                    // The CPU finishes pending write cycles before it freezes.
                    if (cpu_rw) begin
                        r_state <= r_parity ? ALIGN : READ;
                    end
                end
                ALIGN: begin
                    r_state <= READ;
                end
                READ: begin
                    r_buf   <= bus_db;
                    r_state <= WRITE;
                end
                WRITE: begin
                    r_idx <= r_idx + 8'd1;
                    if (r_idx == 8'hFF) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= READ;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Moore output decode; the address never carries out of the page.
    assign o_rdy      = (r_state == IDLE);
    assign dma_active = (r_state == READ) || (r_state == WRITE);
    assign dma_ab     = (r_state == READ)  ? {r_page, r_idx} :
                        (r_state == WRITE) ? DEST_ADDR : 16'h0000;
    assign dma_rw     = (r_state != WRITE);
    assign dma_db     = (r_state == WRITE) ? r_buf : 8'h00;
    assign o_done     = r_done;
    assign o_state    = r_state;

endmodule
